// File: rtl/seq_scheduler.sv
// Batch scheduler: host-configured repeat/gap sequencer trigger with done/busy status.
// Optional watchdog on WAIT enabled by defining SEQ_SCHED_TIMEOUT_EN.
module seq_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dato,
  input  logic       Stb,
  input  logic       wr,
  input  logic       start,
  input  logic       abort,
  input  logic       flag_adc,
  output logic       seq_en,
  output logic [1:0] mode,
  output logic [7:0] mux_cont_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] run_cnt,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT,
    GAP,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] n_q, n_d;
  logic [7:0] g_q, g_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [7:0] gap_q, gap_d;
  logic       flag_q;
  logic       rise;
  logic       is_busy;
  logic [7:0] cnt_inc;

`ifdef SEQ_SCHED_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  assign is_busy = (state_q != IDLE);
  assign rise    = flag_adc & ~flag_q;
  assign cnt_inc = run_cnt_q + 8'd1;

  // Config byte loader; pointer resets whenever the write window closes
  always_comb begin
    ptr_d  = ptr_q;
    mode_d = mode_q;
    mask_d = mask_q;
    n_d    = n_q;
    g_d    = g_q;
    if (!wr) begin
      ptr_d = 2'd0;
    end else if (Stb && !is_busy) begin
      ptr_d = ptr_q + 2'd1;
      unique case (ptr_q)
        2'd0: mode_d = dato[1:0];
        2'd1: mask_d = dato;
        2'd2: n_d    = dato;
        2'd3: g_d    = dato;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    gap_d     = gap_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            run_cnt_d = 8'd0;
`ifdef SEQ_SCHED_TIMEOUT_EN
            wd_d      = 16'd0;
            err_d     = 1'b0;
`endif
            state_d   = (n_q != 8'd0) ? FIRE : DONE;
          end
        end
        FIRE: begin
`ifdef SEQ_SCHED_TIMEOUT_EN
          wd_d    = 16'd0;
`endif
          state_d = WAIT;
        end
        WAIT: begin
          if (rise) begin
            run_cnt_d = cnt_inc;
            if (cnt_inc == n_q) begin
              state_d = DONE;
            end else if (g_q != 8'd0) begin
              gap_d   = g_q;
              state_d = GAP;
            end else begin
              state_d = FIRE;
            end
          end
`ifdef SEQ_SCHED_TIMEOUT_EN
          // 16'hFFFE here means this is the 65535th WAIT cycle
          else if (wd_q == 16'hFFFE) begin
            wd_d    = 16'hFFFF;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            wd_d = wd_q + 16'd1;
          end
`endif
        end
        GAP: begin
          if (gap_q <= 8'd1) begin
            state_d = FIRE;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'd0;
      mask_q    <= 8'd0;
      n_q       <= 8'd0;
      g_q       <= 8'd0;
      ptr_q     <= 2'd0;
      run_cnt_q <= 8'd0;
      gap_q     <= 8'd0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      n_q       <= n_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      run_cnt_q <= run_cnt_d;
      gap_q     <= gap_d;
      flag_q    <= flag_adc;
    end
  end

`ifdef SEQ_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= 16'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Status decoded from state so reset drops them without a clock
  assign seq_en      = (state_q == FIRE);
  assign busy        = is_busy;
  assign done        = (state_q == DONE);
  assign mode        = mode_q;
  assign mux_cont_en = mask_q;
  assign run_cnt     = run_cnt_q;

endmodule
